serial_demux8_deser: RTL and testbench

//  Receive end of the 8:1 bit-serial link. Upstream, an 8:1 mux driven by a

---
 rtl/demux_pkg.sv | 21 ++
 rtl/slot_counter.sv | 38 +++
 rtl/serial_demux8_deser.sv | 121 ++++++++++++
 tb/tb_serial_demux8_deser.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared types and defaults for the 8:1 serial demux/deser.
//                Holds the FSM state encoding and default word geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    // Default word geometry: one bit per slot, slot index wide enough for WIDTH
    localparam int c_WIDTH_DEF = 8;
    localparam int c_SEL_W_DEF = 3;

    // Receive FSM: waiting for a slot-0 bit, or assembling a partial word
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/slot_counter.sv
`default_nettype none
// ============================================================================
//  Module      : slot_counter
//  Description : SEL_W-bit slot index counter with synchronous clear,
//                load-to-one and count enable. Wraps naturally modulo
//                2**SEL_W. Also usable as the transmit-side mux select.
//  Revision    : 1.0 - initial release
// ============================================================================
module slot_counter #(
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load1,
    input  logic             i_en,
    output logic [SEL_W-1:0] o_count
);

    localparam logic [SEL_W-1:0] c_ONE = {{(SEL_W-1){1'b0}}, 1'b1};

    logic [SEL_W-1:0] r_count;

    // Clear beats load-to-one beats increment; increment wraps on overflow
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_load1) begin
            r_count <= c_ONE;
        end else if (i_en) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_count = r_count;

endmodule : slot_counter
`default_nettype wire

// File: rtl/serial_demux8_deser.sv
`default_nettype none
// ============================================================================
//  Module      : serial_demux8_deser
//  Description : Receive end of the 8:1 bit-serial link. Demultiplexes each
//                serial bit into its slot position, rebuilds the parallel
//                word and presents it on a valid/ready output port with a
//                one-deep holding buffer and a sticky overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_demux8_deser
    import demux_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEF,
    parameter int SEL_W = c_SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_first,
    output logic [WIDTH-1:0] out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] slot,
    output logic             busy,
    output logic             overrun
);

    localparam logic [SEL_W-1:0] c_LAST_SLOT = SEL_W'(WIDTH - 1);

    // Top slot is never stored: it is taken straight from in_bit on completion
    logic [WIDTH-2:0] r_asm;
    logic [WIDTH-1:0] r_out_word;
    logic             r_out_valid;
    logic             r_overrun;
    state_e           r_state;
    logic [SEL_W-1:0] r_slot;

    logic             w_collect;
    logic             w_start;
    logic             w_last;
    logic             w_complete;
    logic             w_advance;
    logic             w_can_load;
    logic [WIDTH-1:0] w_word;

    assign w_collect  = (r_state == COLLECT);
    // A slot-0 bit starts a word from IDLE and resyncs a partial one in COLLECT
    assign w_start    = in_valid & in_first;
    assign w_last     = (r_slot == c_LAST_SLOT);
    assign w_complete = w_collect & in_valid & ~in_first & w_last;
    assign w_advance  = w_collect & in_valid & ~in_first & ~w_last;
    // Output buffer is free if empty or being drained on this very edge
    assign w_can_load = ~r_out_valid | out_ready;
    assign w_word     = {in_bit, r_asm};

    slot_counter #(
        .SEL_W (SEL_W)
    ) u_slot_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_complete),
        .i_load1 (w_start),
        .i_en    (w_advance),
        .o_count (r_slot)
    );

    // Receive FSM, assembly register and output buffer with overrun tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_asm       <= '0;
            r_out_word  <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_complete) begin
                if (w_can_load) begin
                    r_out_word  <= w_word;
                    r_out_valid <= 1'b1;
                end else begin
                    r_overrun   <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_asm    <= '0;
                        r_asm[0] <= in_bit;
                        r_state  <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (w_start) begin
                        // Resync: drop the partial word and restart at slot 0
                        r_asm    <= '0;
                        r_asm[0] <= in_bit;
                    end else if (w_complete) begin
                        r_state <= IDLE;
                    end else if (in_valid) begin
                        r_asm[r_slot] <= in_bit;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_word  = r_out_word;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;
    assign slot      = r_slot;
    assign busy      = w_collect;

endmodule : serial_demux8_deser
`default_nettype wire

// File: tb/tb_serial_demux8_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_demux8_deser
//  Description : Self-checking bench for serial_demux8_deser. Directed
//                scenarios plus a randomized run against a word-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_demux8_deser;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_bit;
    logic       in_first;
    logic [7:0] out_word;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] slot;
    logic       busy;
    logic       overrun;

    int checks;
    int failures;

    // Reference model: bit count of the word in progress and its value
    int       m_cnt;
    int       m_acc;
    logic [7:0] m_word;
    bit       m_vld;
    bit       m_ovr;

    serial_demux8_deser #(
        .WIDTH (8),
        .SEL_W (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_first  (in_first),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .slot      (slot),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive inputs, take the edge, advance the model, settle
    task automatic step(input bit r, input bit v, input bit b, input bit f, input bit rdy);
        bit cons;
        bit done;
        rst = r; in_valid = v; in_bit = b; in_first = f; out_ready = rdy;
        @(posedge clk);
        if (r) begin
            m_cnt = 0; m_acc = 0; m_word = '0; m_vld = 0; m_ovr = 0;
        end else begin
            cons = m_vld && rdy;
            done = 0;
            if (v) begin
                if (f) begin
                    m_cnt = 1;
                    m_acc = int'(b);
                end else if (m_cnt > 0) begin
                    m_acc = m_acc | (int'(b) << m_cnt);
                    m_cnt++;
                    if (m_cnt == 8) begin
                        done  = 1;
                        m_cnt = 0;
                    end
                end
            end
            if (done) begin
                if (!m_vld || cons) begin
                    m_word = m_acc[7:0];
                    m_vld  = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (cons) begin
                m_vld = 0;
            end
        end
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input bit rdy);
        for (int i = 0; i < 8; i++) step(0, 1, w[i], (i == 0), rdy);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1);
        checks++;
        if ({out_valid, out_word, slot, busy, overrun} !== 14'd0) begin
            failures++;
            $display("FAIL reset: valid=%0b word=%h slot=%0d busy=%0b ovr=%0b, want all zero",
                     out_valid, out_word, slot, busy, overrun);
        end
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_basic();
        logic [7:0] w;
        w = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, w[i], (i == 0), 1);
            if (i < 7) begin
                checks++;
                if (slot !== 3'(i + 1) || busy !== 1'b1 || out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_slot bit %0d: slot=%0d busy=%0b valid=%0b, want slot=%0d busy=1 valid=0",
                             i, slot, busy, out_valid, i + 1);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_word !== 8'hAA || slot !== 3'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_word: valid=%0b word=%h slot=%0d busy=%0b, want 1 aa 0 0",
                     out_valid, out_word, slot, busy);
        end
        step(0, 0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0 || out_word !== 8'hAA) begin
            failures++;
            $display("FAIL basic_pulse: valid=%0b word=%h, want 0 aa", out_valid, out_word);
        end
    endtask

    task automatic test_gapped();
        logic [7:0] w;
        w = 8'h3C;
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, w[i], (i == 0), 1);
        for (int g = 0; g < 2; g++) begin
            step(0, 0, ~w[4], 0, 1);
            checks++;
            if (slot !== 3'd4 || busy !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL gap_hold %0d: slot=%0d busy=%0b valid=%0b, want 4 1 0",
                         g, slot, busy, out_valid);
            end
        end
        for (int i = 4; i < 8; i++) step(0, 1, w[i], 0, 1);
        checks++;
        if (out_valid !== 1'b1 || out_word !== 8'h3C) begin
            failures++;
            $display("FAIL gap_word: valid=%0b word=%h, want 1 3c", out_valid, out_word);
        end
    endtask

    task automatic test_backpressure();
        step(1, 0, 0, 0, 0);
        send_word(8'h0F, 0);
        checks++;
        if (out_valid !== 1'b1 || out_word !== 8'h0F || overrun !== 1'b0) begin
            failures++;
            $display("FAIL bp_first: valid=%0b word=%h ovr=%0b, want 1 0f 0", out_valid, out_word, overrun);
        end
        send_word(8'hF0, 0);
        checks++;
        if (out_valid !== 1'b1 || out_word !== 8'h0F || overrun !== 1'b1) begin
            failures++;
            $display("FAIL bp_drop: valid=%0b word=%h ovr=%0b, want 1 0f 1", out_valid, out_word, overrun);
        end
        step(0, 0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0 || out_word !== 8'h0F || overrun !== 1'b1) begin
            failures++;
            $display("FAIL bp_drain: valid=%0b word=%h ovr=%0b, want 0 0f 1", out_valid, out_word, overrun);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        logic [7:0] seen [$];
        int         at [$];
        int         cyc;
        words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
        step(1, 0, 0, 0, 1);
        cyc = 0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                step(0, 1, words[k][i], (i == 0), 1);
                cyc++;
                if (out_valid === 1'b1) begin seen.push_back(out_word); at.push_back(cyc); end
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1);
            cyc++;
            if (out_valid === 1'b1) begin seen.push_back(out_word); at.push_back(cyc); end
        end
        checks++;
        if (seen.size() != 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d valid cycles, want 3", seen.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (seen[k] !== words[k] || at[k] != 8 * (k + 1)) begin
                    failures++;
                    $display("FAIL b2b_word %0d: word=%h at cycle %0d, want %h at %0d",
                             k, seen[k], at[k], words[k], 8 * (k + 1));
                end
            end
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ovr: ovr=%0b, want 0", overrun);
        end
    endtask

    task automatic test_resync();
        logic [7:0] w;
        logic [7:0] seen [$];
        w = 8'h5A;
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1'($urandom), (i == 0), 1);
            if (out_valid === 1'b1) seen.push_back(out_word);
        end
        checks++;
        if (slot !== 3'd5) begin
            failures++;
            $display("FAIL resync_slot: slot=%0d, want 5", slot);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 1, w[i], (i == 0), 1);
            if (out_valid === 1'b1) seen.push_back(out_word);
        end
        step(0, 0, 0, 0, 1);
        checks++;
        if (seen.size() != 1 || seen[0] !== 8'h5A || overrun !== 1'b0) begin
            failures++;
            $display("FAIL resync_word: outputs=%0d first=%h ovr=%0b, want 1 5a 0",
                     seen.size(), (seen.size() > 0) ? seen[0] : 8'h00, overrun);
        end
    endtask

    task automatic test_reset_midword();
        logic [7:0] w;
        step(1, 0, 0, 0, 0);
        send_word(8'h11, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1'($urandom), (i == 0), 0);
        checks++;
        if (slot !== 3'd4 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre: slot=%0d valid=%0b, want 4 1", slot, out_valid);
        end
        step(1, 0, 0, 0, 0);
        checks++;
        if (slot !== 3'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_post: slot=%0d busy=%0b valid=%0b, want 0 0 0", slot, busy, out_valid);
        end
        w = 8'hC3;
        send_word(w, 1);
        checks++;
        if (out_valid !== 1'b1 || out_word !== 8'hC3 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL midrst_word: valid=%0b word=%h ovr=%0b, want 1 c3 0", out_valid, out_word, overrun);
        end
    endtask

    task automatic test_random();
        bit r, v, b, f, rdy;
        step(1, 0, 0, 0, 1);
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 299) == 0);
            v   = ($urandom_range(0, 3) != 0);
            b   = 1'($urandom);
            f   = (m_cnt == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            step(r, v, b, f, rdy);
            checks++;
            if ({out_valid, out_word, slot, busy, overrun} !==
                {m_vld, m_word, m_cnt[2:0], (m_cnt != 0), m_ovr}) begin
                failures++;
                $display("FAIL random cycle %0d: valid=%0b word=%h slot=%0d busy=%0b ovr=%0b, want %0b %h %0d %0b %0b",
                         n, out_valid, out_word, slot, busy, overrun,
                         m_vld, m_word, m_cnt[2:0], (m_cnt != 0), m_ovr);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_cnt = 0; m_acc = 0; m_word = '0; m_vld = 0; m_ovr = 0;
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_first = 1'b0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_gapped();
        test_backpressure();
        test_back_to_back();
        test_resync();
        test_reset_midword();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_demux8_deser
`default_nettype wire
